// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator: compares x and y DIGIT bits per cycle,
// MSB digit first, stopping at the first differing digit.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] msb_mask;
  logic [DIGIT-1:0] dx;
  logic [DIGIT-1:0] dy;
  logic             accept;
  logic             idx_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    msb_mask   = '0;
    // Flipping both sign bits maps two's-complement order onto unsigned order.
    msb_mask[WIDTH-1] = signed_mode;
    dx         = DIGIT'(xr >> (DIGIT * int'(idx)));
    dy         = DIGIT'(yr >> (DIGIT * int'(idx)));
    idx_last   = (idx == '0);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if ((dx != dy) || idx_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = COMPARE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy = (state == COMPARE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr   <= '0;
      yr   <= '0;
      idx  <= '0;
      o_gt <= 1'b0;
      o_eq <= 1'b0;
      o_lt <= 1'b0;
    end else if (accept) begin
      xr   <= x ^ msb_mask;
      yr   <= y ^ msb_mask;
      idx  <= TOP_IDX;
      o_gt <= 1'b0;
      o_eq <= 1'b0;
      o_lt <= 1'b0;
    end else if (state == COMPARE) begin
      if (dx > dy) begin
        o_gt <= 1'b1;
      end else if (dx < dy) begin
        o_lt <= 1'b1;
      end else if (idx_last) begin
        o_eq <= 1'b1;
      end else begin
        idx <= idx - IW'(1);
      end
    end
  end

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 2, giving the bits compared per cycle; WIDTH SHALL be a multiple of DIGIT, and NDIG = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a comparison.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: 1 means two's-complement operands, 0 means unsigned.
REQ-007 The block SHALL have port x, input, WIDTH bits: first operand.
REQ-008 The block SHALL have port y, input, WIDTH bits: second operand.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a result becomes valid.
REQ-011 The block SHALL have ports o_gt, o_eq and o_lt, outputs, 1 bit each: x>y, x==y and x<y for the last completed comparison.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, COMPARE, DONE.
REQ-013 A start sampled high in IDLE or DONE SHALL be accepted: latch x, y and signed_mode; set the digit index to NDIG-1 (the MSB digit); clear o_gt, o_eq and o_lt; go to COMPARE.
REQ-014 In signed mode, the operand MSBs SHALL be inverted at latch time, so that the remaining comparison is unsigned.
REQ-015 Each cycle in COMPARE SHALL compare one DIGIT-bit digit of the latched x and y, MSB digit first, as unsigned values.
REQ-016 Digits unequal SHALL set o_gt or o_lt accordingly and go to DONE at the same edge (early termination).
REQ-017 Digits equal with index > 0 SHALL decrement the index and stay in COMPARE.
REQ-018 Digits equal with index 0 SHALL set o_eq and go to DONE.
REQ-019 Latency: if the first differing digit is the m-th digit from the MSB (1-based), done SHALL be high in the cycle after the m-th rising edge following the accepting edge; for equal operands m = NDIG.
REQ-020 done SHALL be high exactly while in DONE, which lasts one cycle; DONE SHALL then go to IDLE, or to COMPARE if start is high.
REQ-021 busy SHALL be high exactly while in COMPARE.
REQ-022 Exactly one of o_gt, o_eq and o_lt SHALL be high from done onward, and SHALL be held until the next accepted start.
REQ-023 start while in COMPARE SHALL be ignored, and x, y and signed_mode changes during COMPARE SHALL NOT affect the result.
REQ-024 Back-to-back operation: start held high SHALL yield a new accepted comparison every (m+1) cycles.
REQ-025 With DIGIT = WIDTH (NDIG = 1), every comparison SHALL complete with done one cycle after acceptance.

Reset
REQ-026 rst high SHALL immediately force IDLE, busy=0, done=0, o_gt=0, o_eq=0, o_lt=0, and clear the latched operands and index, independent of clk.
REQ-027 rst asserted mid-COMPARE SHALL abort the comparison, with no done pulse.
REQ-028 After rst deasserts, the first rising edge with start high SHALL be accepted normally.

Verification (WIDTH=8, DIGIT=2, NDIG=4)
REQ-029 The bench SHALL cover reset: assert rst asynchronously between edges -> all outputs 0 before the next edge; state IDLE.
REQ-030 The bench SHALL cover unsigned early exit: x=0x80, y=0x7F, signed_mode=0 -> o_gt=1; done one cycle after acceptance; busy high for one cycle.
REQ-031 The bench SHALL cover signed mode: x=0x80, y=0x7F, signed_mode=1 -> o_lt=1 (-128<127); done one cycle after acceptance.
REQ-032 The bench SHALL cover full-length and equal operands: x=0x26, y=0x27 unsigned -> o_lt=1 with done 4 cycles after acceptance; x=y=0x5A -> o_eq=1 with done 4 cycles after acceptance.
REQ-033 The bench SHALL cover a start pulse during COMPARE, with x and y changed mid-run -> ignored; the result matches the latched operands.
REQ-034 The bench SHALL cover rst mid-COMPARE -> no done pulse, outputs 0; then start held with 10 random operand pairs, back-to-back -> each result matches a reference model, with flags held between done pulses.
